execute_muldiv: RTL and testbench
=================================

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port valid, input, 1 bit: the execute stage presents an M-extension operation.
REQ-004 SHALL have port op, input, 3 bits: the RV64M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-005 SHALL have port word, input, 1 bit: selects the W variant (MULW, DIVW, DIVUW, REMW, REMUW).
REQ-006 SHALL have ports a and b, input, 64 bits each: rs1 and rs2 operands after forwarding.
REQ-007 SHALL have port flush, input, 1 bit: pipeline flush, which aborts any operation in progress.
REQ-008 SHALL have port ready, output, 1 bit: the unit is idle and can accept an operation.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, 64 bits: value forwarded into the execute result field consumed by the memory stage.

Function
REQ-011 SHALL accept an operation only in a cycle where valid=1, ready=1 and flush=0.
REQ-012 SHALL implement states IDLE, BUSY and DONE; the transitions are IDLE->BUSY on accept, BUSY->DONE after 64 BUSY cycles, DONE->IDLE unconditionally.
REQ-013 SHALL drive ready=1 only in IDLE, and done=1 only in DONE.
REQ-014 SHALL assert done exactly 65 cycles after the accept cycle, with identical latency for all ops, including special cases.
REQ-015 SHALL hold result stable from the DONE cycle until the next accepted operation's DONE cycle.
REQ-016 SHALL ignore valid while in BUSY or DONE; operands are latched at accept, and later changes to a/b/op have no effect.
REQ-017 SHALL compute multiply by 1-bit-per-cycle shift-add on operand magnitudes into a 128-bit product, then negate if the operand signs differ (per MULH/MULHSU/MULHU signedness).
REQ-018 SHALL return product[63:0] for MUL and product[127:64] for MULH/MULHSU/MULHU.
REQ-019 SHALL compute divide by 1-bit-per-cycle restoring division on magnitudes; the quotient sign is the XOR of the operand signs, and the remainder takes the dividend's sign.
REQ-020 SHALL, on divide-by-zero, return quotient all-ones and remainder equal to the dividend.
REQ-021 SHALL, on signed overflow (most-negative / -1), return quotient equal to the dividend and remainder 0.
REQ-022 SHALL, when word=1, use a[31:0]/b[31:0], sign-extended for signed ops and zero-extended for unsigned ops, and sign-extend result[31:0] to 64 bits.
REQ-023 SHALL apply the word-mode special-case values (REQ-020, REQ-021) at 32-bit width.
REQ-024 SHALL return result 0 when word=1 with op 001, 010 or 011; the latency still follows REQ-014.
REQ-025 SHALL, on flush=1 in any state, go to IDLE next cycle without asserting done; result is unchanged.
REQ-026 SHALL give flush priority when flush and valid arrive in the same cycle; no operation is accepted.
REQ-027 SHALL implement the iteration counter as 6 bits, wrapping 63->0 on the BUSY->DONE transition.

Reset
REQ-028 SHALL, when resetn=0 at a rising clk edge, set state IDLE, counter 0, done 0, result 0, and ready 1 from the following cycle.
REQ-029 SHALL treat reset during BUSY or DONE like flush: the in-flight operation is discarded and no done pulse occurs.
REQ-030 SHALL give reset priority over flush and valid.

Structure
REQ-031 SHALL place the muldiv_op_t enumeration (funct3 encodings) in package pipes.
REQ-032 SHALL place the MULDIV_ITER=64 constant in package common.
REQ-033 SHALL implement the FSM and shared shift datapath in this single module with no sub-module; the execute stage instantiates it and stalls upstream while ready=0 and done=0.

Verification
REQ-034 SHALL verify multiply: MUL a=7, b=-3 -> done at +65 cycles, result=0xFFFF_FFFF_FFFF_FFEB.
REQ-035 SHALL verify high multiply: MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE; MULH with the same operands -> 0.
REQ-036 SHALL verify division: DIV a=-20, b=3 -> result=-6; REM -> -2; DIVU a=20, b=0 -> all-ones; REMU a=20, b=0 -> 20.
REQ-037 SHALL verify overflow: DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; DIVW a=0x8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000.
REQ-038 SHALL verify word multiply: MULW a=0x7FFF_FFFF, b=2 -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-039 SHALL verify abort: flush 10 cycles after accept -> no done, ready=1 next cycle; a new MUL 2x3 then gives result=6 at +65; resetn=0 mid-BUSY -> the same abort behaviour.

Source files
------------

// File: rtl/common.sv
// Constants shared across the pipeline stages.
package common;

   localparam int unsigned MULDIV_ITER = 64;

endpackage

// File: rtl/pipes.sv
// Encodings exchanged between pipeline stages.
package pipes;

   // RV64M funct3
   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } muldiv_op_t;

endpackage

// File: rtl/execute_muldiv.sv
// Iterative RV64M multiply/divide unit: one shift-add or restoring-divide step per
// cycle on operand magnitudes, fixed 65-cycle accept-to-done latency.
module execute_muldiv
   import common::*;
   import pipes::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid,
   input  logic [2:0]  op,
   input  logic        word,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        flush,
   output logic        ready,
   output logic        done,
   output logic [63:0] result
);

   localparam logic [5:0] LAST_COUNT = 6'(MULDIV_ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t      state, state_nx;
   logic        accept, last;
   logic [5:0]  count;

   muldiv_op_t  op_in, op_q;
   logic        word_q, neg_q, rneg_q, dz_q, ovf_q;
   logic [63:0] dividend_q, opb_q, hi, lo;

   logic        a_signed, b_signed, sa, sb, dz, ovf;
   logic [63:0] a_ext, b_ext, a_mag, b_mag;

   logic [64:0]  mul_sum, rem_sh, diff;
   logic [63:0]  hi_nx, lo_nx, quo, rem, res_nx;
   logic [127:0] prod;

   assign op_in = muldiv_op_t'(op);

   always_ff @(posedge clk) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      last     = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (valid && !flush) begin
               accept   = 1'b1;
               state_nx = S_BUSY;
            end
         end
         S_BUSY: begin
            if (count == LAST_COUNT) begin
               last     = 1'b1;
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (flush) begin
         state_nx = S_IDLE;
         last     = 1'b0;
      end
   end

   // Operand conditioning at accept: width/sign extension, magnitudes, special cases.
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op_in)
         MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         MD_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
      a_ext = a;
      b_ext = b;
      if (word) begin
         a_ext = a_signed ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
         b_ext = b_signed ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
      end
      sa    = a_signed & a_ext[63];
      sb    = b_signed & b_ext[63];
      a_mag = sa ? -a_ext : a_ext;
      b_mag = sb ? -b_ext : b_ext;
      dz    = (b_ext == '0);
      ovf   = a_signed && b_signed && (b_ext == '1) &&
              (word ? (a_ext == 64'hFFFF_FFFF_8000_0000) : (a_ext == 64'h8000_0000_0000_0000));
   end

   // Shared step: divide shifts {hi,lo} left with trial subtract, multiply shifts right with add.
   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb_q} : 65'h0);
      rem_sh  = {hi, lo[63]};
      diff    = rem_sh - {1'b0, opb_q};
      if (op_q[2]) begin
         hi_nx = diff[64] ? rem_sh[63:0] : diff[63:0];
         lo_nx = {lo[62:0], ~diff[64]};
      end else begin
         hi_nx = mul_sum[64:1];
         lo_nx = {mul_sum[0], lo[63:1]};
      end
   end

   always_comb begin
      prod = {hi_nx, lo_nx};
      if (neg_q) prod = -prod;
      quo = neg_q  ? -lo_nx : lo_nx;
      rem = rneg_q ? -hi_nx : hi_nx;
      if (dz_q) begin
         quo = '1;
         rem = dividend_q;
      end
      if (ovf_q) begin
         quo = dividend_q;
         rem = '0;
      end
      case (op_q)
         MD_MUL:                       res_nx = prod[63:0];
         MD_MULH, MD_MULHSU, MD_MULHU: res_nx = word_q ? 64'h0 : prod[127:64];
         MD_DIV, MD_DIVU:              res_nx = quo;
         default:                      res_nx = rem;
      endcase
      if (word_q) res_nx = {{32{res_nx[31]}}, res_nx[31:0]};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count      <= '0;
         result     <= '0;
         op_q       <= MD_MUL;
         word_q     <= 1'b0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         dz_q       <= 1'b0;
         ovf_q      <= 1'b0;
         dividend_q <= '0;
         opb_q      <= '0;
         hi         <= '0;
         lo         <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (accept) begin
         count      <= '0;
         op_q       <= op_in;
         word_q     <= word;
         neg_q      <= sa ^ sb;
         rneg_q     <= sa;
         dz_q       <= dz;
         ovf_q      <= ovf;
         dividend_q <= a_ext;
         opb_q      <= b_mag;
         hi         <= '0;
         lo         <= a_mag;
      end else if (state == S_BUSY) begin
         count <= count + 6'd1;
         hi    <= hi_nx;
         lo    <= lo_nx;
         if (last) result <= res_nx;
      end
   end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed self-checking bench for execute_muldiv: vector table plus abort sequences.
module tb_execute_muldiv;

   logic        clk = 1'b0;
   logic        resetn, valid, word, flush;
   logic [2:0]  op;
   logic [63:0] a, b;
   logic        ready, done;
   logic [63:0] result;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [2:0]  op;
      logic        word;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs[NV];

   execute_muldiv dut (
      .clk    (clk),
      .resetn (resetn),
      .valid  (valid),
      .op     (op),
      .word   (word),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .ready  (ready),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Accept one op, hold valid high and scramble operands while busy, then time done.
   task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] x,
                         input logic [63:0] y, output logic [63:0] res, output int lat);
      @(negedge clk);
      valid = 1'b1; op = o; word = w; a = x; b = y;
      @(posedge clk);
      @(negedge clk);
      check("busy_ready", {63'h0, ready}, 64'h0);
      op = ~o;
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      lat = 1;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      res   = result;
      valid = 1'b0;
      @(negedge clk);
      check("after_done_pulse", {62'h0, done, ready}, 64'h1);
      check("result_hold", result, res);
   endtask

   task automatic watch_no_done(input int ncyc, input string name);
      int pulses = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      check(name, 64'(pulses), 64'h0);
   endtask

   initial begin
      logic [63:0] res;
      int          lat;

      vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
      vecs[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[2]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      vecs[3]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA};
      vecs[4]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[5]  = '{3'd5, 1'b0, 64'd20, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[6]  = '{3'd7, 1'b0, 64'd20, 64'd0, 64'd20};
      vecs[7]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
      vecs[8]  = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
      vecs[9]  = '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[10] = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[11] = '{3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2};
      vecs[12] = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[13] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9};
      vecs[14] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      vecs[15] = '{3'd5, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF};
      vecs[16] = '{3'd6, 1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[17] = '{3'd4, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[18] = '{3'd7, 1'b1, 64'hDEAD_BEEF_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005};
      vecs[19] = '{3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      vecs[20] = '{3'd0, 1'b1, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_0000_0005, 64'd15};
      vecs[21] = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14};
      vecs[22] = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2};
      vecs[23] = '{3'd0, 1'b0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h0};
      vecs[24] = '{3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      vecs[25] = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};

      resetn = 1'b0; valid = 1'b0; flush = 1'b0; word = 1'b0; op = 3'd0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", {63'h0, ready}, 64'h1);
      check("reset_done", {63'h0, done}, 64'h0);
      check("reset_result", result, 64'h0);
      resetn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, res, lat);
         check($sformatf("latency[%0d]", i), 64'(lat), 64'd65);
         check($sformatf("result[%0d]", i), res, vecs[i].exp);
      end

      // Flush ten cycles after accept: no done, idle next cycle, result kept.
      @(negedge clk);
      valid = 1'b1; op = 3'd0; word = 1'b0; a = 64'd5; b = 64'd5;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_ready", {63'h0, ready}, 64'h1);
      check("flush_done", {63'h0, done}, 64'h0);
      watch_no_done(70, "flush_no_done");
      check("flush_result_kept", result, vecs[NV-1].exp);

      run_op(3'd0, 1'b0, 64'd2, 64'd3, res, lat);
      check("post_flush_latency", 64'(lat), 64'd65);
      check("post_flush_result", res, 64'd6);

      // Flush and valid together: nothing accepted.
      @(negedge clk);
      valid = 1'b1; flush = 1'b1; op = 3'd0; a = 64'd9; b = 64'd9;
      @(negedge clk);
      valid = 1'b0; flush = 1'b0;
      check("flush_valid_idle", {63'h0, ready}, 64'h1);
      watch_no_done(70, "flush_valid_no_done");
      check("flush_valid_result", result, 64'd6);

      // Reset mid-busy behaves like an abort.
      @(negedge clk);
      valid = 1'b1; op = 3'd4; a = 64'd100; b = 64'd3;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      repeat (20) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("rst_busy_ready", {63'h0, ready}, 64'h1);
      check("rst_busy_result", result, 64'h0);
      watch_no_done(70, "rst_busy_no_done");

      run_op(3'd0, 1'b0, 64'd2, 64'd3, res, lat);
      check("post_rst_latency", 64'(lat), 64'd65);
      check("post_rst_result", res, 64'd6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
